// File: rtl/turbo_iter_ctrl.sv
// -----------------------------------------------------------------------------
// turbo_iter_ctrl
//
// Iteration controller for a turbo decoder that time-shares one SISO core
// between constituent decoder 1 (natural order, parity 1) and decoder 2
// (interleaved order, parity 2). Each half-iteration has three phases:
//   1. Stream the block out of the symbol/extrinsic memories.
//   2. Wait for the SISO to report completion.
//   3. Sequence the extrinsic write-back.
// Full iterations repeat until the programmed count is reached. The final
// write-back is flagged so that the datapath stores hard decisions.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        asynchronous active-low reset
//   start_i        start a decode (accepted only while idle)
//   n_iter_i       number of full iterations, sampled at start (0 acts as 1)
//   siso_done_i    SISO result-ready pulse (observed only while waiting)
//   busy_o         high whenever the controller is not idle
//   mem_rd_en_o    memory read strobe
//   mem_rd_addr_o  logical read index (the memory interleaves when half_o=1)
//   half_o         0 = SISO1 natural order, 1 = SISO2 interleaved order
//   siso_read_en_o data-valid to the SISO (read strobe delayed one cycle)
//   ext_wr_en_o    extrinsic/LLR write strobe
//   ext_wr_addr_o  write index, also used as the LLR select index
//   final_o        high through the last write-back (hard-decision store)
//   iter_o         current full-iteration index, 0-based
//   done_o         one-cycle pulse on normal completion
//   err_o          one-cycle pulse on SISO timeout abort
//
// Every output is taken straight from a flop. Each flop is loaded with the
// value that belongs to the state being entered, so the strobes never glitch.
// -----------------------------------------------------------------------------
module turbo_iter_ctrl #(
  parameter int BLOCK_LEN = 7,
  parameter int ADDR_W    = 3,
  parameter int ITER_W    = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ITER_W-1:0] n_iter_i,
  input  logic              siso_done_i,
  output logic              busy_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  output logic              half_o,
  output logic              siso_read_en_o,
  output logic              ext_wr_en_o,
  output logic [ADDR_W-1:0] ext_wr_addr_o,
  output logic              final_o,
  output logic [ITER_W-1:0] iter_o,
  output logic              done_o,
  output logic              err_o
);

  // Wide enough to hold TIMEOUT-1 even for very small TIMEOUT values.
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BLOCK_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t              state_r,        state_s;
  logic [ADDR_W-1:0]   rd_addr_r,      rd_addr_s;
  logic                rd_tail_r,      rd_tail_s;   // LOAD: all reads issued, covering memory latency
  logic [ADDR_W-1:0]   wr_addr_r,      wr_addr_s;
  logic [TMO_W-1:0]    tmo_r,          tmo_s;
  logic [ITER_W-1:0]   n_last_r,       n_last_s;    // N-1, the index of the last iteration
  logic [ITER_W-1:0]   iter_r,         iter_s;
  logic                half_r,         half_s;
  logic                final_r,        final_s;
  logic                mem_rd_en_r,    mem_rd_en_s;
  logic                siso_read_en_r;
  logic                ext_wr_en_r,    ext_wr_en_s;
  logic                done_r,         done_s;
  logic                err_r,          err_s;
  logic                busy_r,         busy_s;

  // Next-state and next-output logic: the outputs describe the state being entered.
  always_comb begin
    state_s     = state_r;
    rd_addr_s   = rd_addr_r;
    rd_tail_s   = rd_tail_r;
    wr_addr_s   = wr_addr_r;
    tmo_s       = tmo_r;
    n_last_s    = n_last_r;
    iter_s      = iter_r;
    half_s      = half_r;
    final_s     = 1'b0;
    mem_rd_en_s = 1'b0;
    ext_wr_en_s = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          // A request for zero iterations runs one iteration.
          if (n_iter_i == {ITER_W{1'b0}}) begin
            n_last_s = {ITER_W{1'b0}};
          end else begin
            n_last_s = n_iter_i - ITER_W'(1);
          end
          iter_s      = {ITER_W{1'b0}};
          half_s      = 1'b0;
          rd_addr_s   = {ADDR_W{1'b0}};
          rd_tail_s   = 1'b0;
          mem_rd_en_s = 1'b1;
          state_s     = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (rd_tail_r) begin
          tmo_s   = {TMO_W{1'b0}};
          state_s = ST_WAIT;
        end else if (rd_addr_r == ADDR_LAST) begin
          // Address holds at the last index; one more cycle for read data.
          rd_tail_s = 1'b1;
        end else begin
          rd_addr_s   = rd_addr_r + ADDR_W'(1);
          mem_rd_en_s = 1'b1;
        end
      end

      ST_WAIT: begin
        if (siso_done_i) begin
          wr_addr_s   = {ADDR_W{1'b0}};
          ext_wr_en_s = 1'b1;
          final_s     = half_r & (iter_r == n_last_r);
          state_s     = ST_WB;
        end else if (tmo_r == TMO_LAST) begin
          err_s   = 1'b1;
          state_s = ST_ERR;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end

      ST_WB: begin
        if (wr_addr_r == ADDR_LAST) begin
          if (final_r) begin
            done_s  = 1'b1;
            state_s = ST_DONE;
          end else begin
            // Swap to the other constituent decoder; advance the
            // iteration after SISO2 has finished.
            if (half_r) begin
              half_s = 1'b0;
              iter_s = iter_r + ITER_W'(1);
            end else begin
              half_s = 1'b1;
            end
            rd_addr_s   = {ADDR_W{1'b0}};
            rd_tail_s   = 1'b0;
            mem_rd_en_s = 1'b1;
            state_s     = ST_LOAD;
          end
        end else begin
          wr_addr_s   = wr_addr_r + ADDR_W'(1);
          ext_wr_en_s = 1'b1;
          final_s     = final_r;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      ST_ERR: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r        <= ST_IDLE;
      rd_addr_r      <= {ADDR_W{1'b0}};
      rd_tail_r      <= 1'b0;
      wr_addr_r      <= {ADDR_W{1'b0}};
      tmo_r          <= {TMO_W{1'b0}};
      n_last_r       <= {ITER_W{1'b0}};
      iter_r         <= {ITER_W{1'b0}};
      half_r         <= 1'b0;
      final_r        <= 1'b0;
      mem_rd_en_r    <= 1'b0;
      siso_read_en_r <= 1'b0;
      ext_wr_en_r    <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      rd_addr_r      <= rd_addr_s;
      rd_tail_r      <= rd_tail_s;
      wr_addr_r      <= wr_addr_s;
      tmo_r          <= tmo_s;
      n_last_r       <= n_last_s;
      iter_r         <= iter_s;
      half_r         <= half_s;
      final_r        <= final_s;
      mem_rd_en_r    <= mem_rd_en_s;
      siso_read_en_r <= mem_rd_en_r;  // matches the one-cycle memory latency
      ext_wr_en_r    <= ext_wr_en_s;
      done_r         <= done_s;
      err_r          <= err_s;
      busy_r         <= busy_s;
    end
  end

  assign busy_o         = busy_r;
  assign mem_rd_en_o    = mem_rd_en_r;
  assign mem_rd_addr_o  = rd_addr_r;
  assign half_o         = half_r;
  assign siso_read_en_o = siso_read_en_r;
  assign ext_wr_en_o    = ext_wr_en_r;
  assign ext_wr_addr_o  = wr_addr_r;
  assign final_o        = final_r;
  assign iter_o         = iter_r;
  assign done_o         = done_r;
  assign err_o          = err_r;

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_turbo_iter_ctrl
//
// Directed bench for turbo_iter_ctrl with default parameters. A SISO model
// answers 5 cycles after the last siso_read_en_o, so each half-iteration takes
// 20 cycles. Counting cycle 1 as the cycle after start_i is sampled, the phases
// of half h are at offsets (20*h + off), where off runs from 1 to 20:
//   reads     off 1..7   (address off-1)
//   SISO data off 2..8
//   WB        off 14..20 (address off-14)
// done_o is high in cycle 40*N+1. Every cycle is compared against that
// timeline.
// -----------------------------------------------------------------------------
module tb_turbo_iter_ctrl;

  localparam int BL = 7;
  localparam int AW = 3;
  localparam int IW = 4;
  localparam int TO = 64;

  logic          clk_i       = 1'b0;
  logic          rst_n_i     = 1'b0;
  logic          start_i     = 1'b0;
  logic [IW-1:0] n_iter_i    = '0;
  logic          siso_done_i = 1'b0;
  logic          busy_o;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic          half_o;
  logic          siso_read_en_o;
  logic          ext_wr_en_o;
  logic [AW-1:0] ext_wr_addr_o;
  logic          final_o;
  logic [IW-1:0] iter_o;
  logic          done_o;
  logic          err_o;

  int n_checks = 0;
  int n_pass   = 0;

  turbo_iter_ctrl #(
    .BLOCK_LEN(BL), .ADDR_W(AW), .ITER_W(IW), .TIMEOUT(TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (start_i),
    .n_iter_i      (n_iter_i),
    .siso_done_i   (siso_done_i),
    .busy_o        (busy_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .half_o        (half_o),
    .siso_read_en_o(siso_read_en_o),
    .ext_wr_en_o   (ext_wr_en_o),
    .ext_wr_addr_o (ext_wr_addr_o),
    .final_o       (final_o),
    .iter_o        (iter_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // All outputs packed together; used where every output must be zero.
  function automatic logic [31:0] all_outputs();
    return {10'd0, busy_o, mem_rd_en_o, siso_read_en_o, ext_wr_en_o, final_o,
            done_o, err_o, half_o, iter_o, mem_rd_addr_o, ext_wr_addr_o};
  endfunction

  // One decode, compared cycle by cycle against the expected timeline.
  //   no_done   : the SISO never answers (timeout run)
  //   poke      : pulse siso_done_i in LOAD and start_i in WB (both ignored)
  //   abort_at  : return right after the checks of this cycle (0 = never)
  task automatic run_decode(input logic [IW-1:0] n_in, input int n_eff,
                            input bit no_done, input bit poke, input int abort_at);
    int   last_rd;
    bit   armed;
    int   k_end;
    int   h;
    int   off;
    bit   in_run;
    bit   stop;
    logic       e_rd, e_sre, e_wr, e_fin, e_busy, e_done, e_err, e_half;
    logic [2:0] e_ra, e_wa;
    logic [3:0] e_iter;

    @(negedge clk_i);
    start_i     = 1'b1;
    n_iter_i    = n_in;
    siso_done_i = 1'b0;
    @(posedge clk_i);
    armed   = 1'b0;
    last_rd = 0;
    stop    = 1'b0;
    k_end   = no_done ? 75 : 40 * n_eff + 3;

    for (int k = 1; k <= k_end && !stop; k++) begin
      @(negedge clk_i);
      start_i     = 1'b0;
      siso_done_i = 1'b0;
      h   = (k - 1) / 20;
      off = (k - 1) % 20 + 1;

      if (no_done) begin
        // LOAD 1..8, WAIT 9..72 (64 cycles), ERR 73
        e_rd   = (k <= 7);
        e_sre  = (k >= 2 && k <= 8);
        e_wr   = 1'b0;
        e_fin  = 1'b0;
        e_busy = (k <= 73);
        e_done = 1'b0;
        e_err  = (k == 73);
        e_ra   = e_rd ? 3'(k - 1) : 3'd0;
        e_wa   = 3'd0;
        e_half = 1'b0;
        e_iter = 4'd0;
      end else begin
        in_run = (h < 2 * n_eff);
        e_rd   = in_run && (off <= 7);
        e_sre  = in_run && (off >= 2) && (off <= 8);
        e_wr   = in_run && (off >= 14);
        e_fin  = e_wr && (h == 2 * n_eff - 1);
        e_busy = (k <= 40 * n_eff + 1);
        e_done = (k == 40 * n_eff + 1);
        e_err  = 1'b0;
        e_ra   = e_rd ? 3'(off - 1) : 3'd0;
        e_wa   = e_wr ? 3'(off - 14) : 3'd0;
        e_half = in_run ? 1'(h % 2) : 1'b1;
        e_iter = in_run ? 4'(h / 2) : 4'(n_eff - 1);
      end

      check_eq("ctl", {25'd0, busy_o, mem_rd_en_o, siso_read_en_o, ext_wr_en_o,
                       final_o, done_o, err_o},
                      {25'd0, e_busy, e_rd, e_sre, e_wr, e_fin, e_done, e_err});
      check_eq("addr", {26'd0, (mem_rd_en_o ? mem_rd_addr_o : 3'd0),
                        (ext_wr_en_o ? ext_wr_addr_o : 3'd0)},
                       {26'd0, e_ra, e_wa});
      check_eq("half_iter", {27'd0, half_o, iter_o}, {27'd0, e_half, e_iter});

      // SISO model: done 5 cycles after the last data-valid
      if (siso_read_en_o) begin
        last_rd = k;
        armed   = 1'b1;
      end else if (armed && !no_done && k == last_rd + 5) begin
        siso_done_i = 1'b1;
        armed       = 1'b0;
      end

      if (poke && h == 0 && off == 3) siso_done_i = 1'b1;
      if (poke && h == 0 && off == 16) begin
        start_i  = 1'b1;
        n_iter_i = 4'd5;
      end

      if (k == abort_at) stop = 1'b1;
    end
    start_i     = 1'b0;
    siso_done_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check_eq("reset_outputs", all_outputs(), 32'd0);
    rst_n_i = 1'b1;

    run_decode(4'd1, 1, 1'b0, 1'b0, 0);   // single iteration, done 40 cycles after start
    run_decode(4'd0, 1, 1'b0, 1'b0, 0);   // zero behaves as one
    run_decode(4'd3, 3, 1'b0, 1'b0, 0);   // iter 0,0,1,1,2,2
    run_decode(4'd2, 2, 1'b0, 1'b1, 0);   // ignored start/done pokes, done at +80
    run_decode(4'd1, 1, 1'b1, 1'b0, 0);   // timeout abort

    // Reset during the third WB cycle (cycle 16)
    run_decode(4'd1, 1, 1'b0, 1'b0, 16);
    rst_n_i = 1'b0;
    #1;
    check_eq("async_reset", all_outputs(), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("held_reset", all_outputs(), 32'd0);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check_eq("post_reset_idle", all_outputs(), 32'd0);
    run_decode(4'd1, 1, 1'b0, 1'b0, 0);   // fresh decode completes normally

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
